// File: rtl/coproc_img_pkg.sv
`default_nettype none
// =============================================================================
// Package     : coproc_img_pkg
// Description : Shared constants and types for the image co-processor row path
//               (pixel format, row/frame geometry, row_writer state encoding).
// Revision    : 1.0 - initial release
// =============================================================================
package coproc_img_pkg;

    // Pixel format: RGB444, R [11:8], G [7:4], B [3:0]
    localparam int PIX_W    = 12;
    // Pixels per row; equals the row accumulator depth
    localparam int ROW_PIX  = 256;
    // Rows per frame
    localparam int NUM_ROWS = 256;
    // Row address width; 2**ROW_AW must cover NUM_ROWS
    localparam int ROW_AW   = 8;
    // Width of the per-row pixel counter
    localparam int PIX_CW   = $clog2(ROW_PIX);

    localparam logic [PIX_CW-1:0] C_LAST_PIX = PIX_CW'(ROW_PIX - 1);
    localparam logic [ROW_AW-1:0] C_LAST_ROW = ROW_AW'(NUM_ROWS - 1);

    typedef logic [PIX_W-1:0] pixel_t;

    // row_writer sequencing states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } rw_state_t;

endpackage : coproc_img_pkg
`default_nettype wire

// File: rtl/row_writer_if.sv
`default_nettype none
// =============================================================================
// Interface   : row_writer_if
// Description : Bundles the row_writer data paths: upstream pixel stream,
//               accumulator write port and image-buffer row-write request.
//               master = row_writer side, slave = its environment.
// Revision    : 1.0 - initial release
// =============================================================================
interface row_writer_if;
    import coproc_img_pkg::*;

    // Upstream pixel stream
    logic                pix_valid;
    pixel_t              pix_data;
    logic                pix_ready;
    // Row accumulator write port
    logic                accum_we;
    pixel_t              accum_wdata;
    // Image buffer row write
    logic                buf_we;
    logic [ROW_AW-1:0]   buf_waddr;
    logic                buf_ready;

    modport master (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output accum_we,
        output accum_wdata,
        output buf_we,
        output buf_waddr,
        input  buf_ready
    );

    modport slave (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  accum_we,
        input  accum_wdata,
        input  buf_we,
        input  buf_waddr,
        output buf_ready
    );

endinterface : row_writer_if
`default_nettype wire

// File: rtl/row_writer.sv
`default_nettype none
// =============================================================================
// Module      : row_writer
// Description : Forwards an RGB444 pixel stream into the 256-entry row
//               accumulator, and after every full row issues one handshaked
//               row write to the image buffer. Sequences NUM_ROWS rows per
//               frame and pulses frame_done after the last row is written.
// Options     : ROW_WRITER_VFLIP_EN - when defined, rows are written bottom-up
//               (first streamed row lands at address NUM_ROWS-1).
// Revision    : 1.0 - initial release
// =============================================================================
module row_writer
    import coproc_img_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    row_writer_if.master     rw,
    output logic             busy,
    output logic             frame_done
);

    rw_state_t              r_state;
    logic [PIX_CW-1:0]      r_pix_cnt;
    logic [ROW_AW-1:0]      r_row_cnt;
    logic                   r_pix_ready;
    logic                   r_busy;
    logic                   r_buf_we;
    logic [ROW_AW-1:0]      r_buf_waddr;
    logic                   r_frame_done;
    logic                   w_accept;

    // Maps the streamed row index to its image-buffer address
    function automatic logic [ROW_AW-1:0] row_to_addr(input logic [ROW_AW-1:0] row);
`ifdef ROW_WRITER_VFLIP_EN
        return C_LAST_ROW - row;
`else
        return row;
`endif
    endfunction

    // A pixel is taken only while filling; ready is a registered FILL flag
    assign w_accept       = rw.pix_valid & r_pix_ready;

    // Zero-latency pass-through to the accumulator, quiet outside FILL
    assign rw.accum_we    = w_accept;
    assign rw.accum_wdata = r_pix_ready ? rw.pix_data : '0;

    assign rw.pix_ready   = r_pix_ready;
    assign rw.buf_we      = r_buf_we;
    assign rw.buf_waddr   = r_buf_waddr;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;

    // Frame sequencer: counters, state and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pix_cnt    <= '0;
            r_row_cnt    <= '0;
            r_pix_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_buf_we     <= 1'b0;
            r_buf_waddr  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= FILL;
                        r_pix_cnt   <= '0;
                        r_row_cnt   <= '0;
                        r_buf_waddr <= row_to_addr('0);
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        if (r_pix_cnt == C_LAST_PIX) begin
                            // Accumulator takes this pixel on the same edge, so
                            // its row output is settled for all of COMMIT.
                            r_pix_cnt   <= '0;
                            r_state     <= COMMIT;
                            r_pix_ready <= 1'b0;
                            r_buf_we    <= 1'b1;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (rw.buf_ready) begin
                        r_buf_we <= 1'b0;
                        if (r_row_cnt == C_LAST_ROW) begin
                            r_state      <= DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_row_cnt   <= r_row_cnt + 1'b1;
                            r_buf_waddr <= row_to_addr(r_row_cnt + 1'b1);
                            r_state     <= FILL;
                            r_pix_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start here is deliberately ignored
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_pix_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_buf_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule : row_writer
`default_nettype wire

// File: tb/tb_row_writer.sv
`default_nettype none
// =============================================================================
// Module      : tb_row_writer
// Description : Self-checking bench for row_writer. A background scoreboard
//               matches accumulator writes against offered pixels and row
//               commits against expected addresses; scenario tasks add their
//               own cycle-accurate checks.
// Options     : ROW_WRITER_VFLIP_EN - flips expected row addresses.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_row_writer;
    import coproc_img_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    row_writer_if rw ();

    row_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rw         (rw),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Stimulus controls
    logic rst_drive   = 1'b1;
    logic ready_drive = 1'b1;
    int   valid_mode  = 1;       // 0 never, 1 always, 2 random
    int   start_q[$];            // cycles at which to pulse start

    // Scoreboard state
    pixel_t            exp_pix_q[$];
    logic [ROW_AW-1:0] exp_addr_q[$];
    int acc_total   = 0;
    int pushed_idx  = -1;
    int row_accepts = 0;
    int commits     = 0;
    int fd_count    = 0;
    int fd_cyc      = -1;
    int busy_cycles = 0;
    pixel_t            mon_pix;
    logic [ROW_AW-1:0] mon_addr;

    function automatic logic [ROW_AW-1:0] exp_addr(input int r);
`ifdef ROW_WRITER_VFLIP_EN
        return ROW_AW'(NUM_ROWS - 1 - r);
`else
        return ROW_AW'(r);
`endif
    endfunction

    // Scoreboard monitor, sampling mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (rw.accum_we !== (rw.pix_valid & rw.pix_ready)) begin
                errors++;
                $display("FAIL accum_we_gate: got %b want %b", rw.accum_we, rw.pix_valid & rw.pix_ready);
            end
            if (rw.accum_we === 1'b1) begin
                acc_total++;
                row_accepts++;
                checks++;
                if (exp_pix_q.size() == 0) begin
                    errors++;
                    $display("FAIL accum_wdata: got %h want nothing (no pixel offered)", rw.accum_wdata);
                end else begin
                    mon_pix = exp_pix_q.pop_front();
                    if (rw.accum_wdata !== mon_pix) begin
                        errors++;
                        $display("FAIL accum_wdata: got %h want %h", rw.accum_wdata, mon_pix);
                    end
                end
            end
            if (busy === 1'b1) busy_cycles++;
            if (frame_done === 1'b1) begin
                fd_count++;
                fd_cyc = cyc;
            end
            if (rw.buf_we === 1'b1 && rw.buf_ready === 1'b1) begin
                checks++;
                if (row_accepts != ROW_PIX) begin
                    errors++;
                    $display("FAIL row_accepts: got %0d want %0d", row_accepts, ROW_PIX);
                end
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL buf_waddr: got %0d want no commit", rw.buf_waddr);
                end else begin
                    mon_addr = exp_addr_q.pop_front();
                    if (rw.buf_waddr !== mon_addr) begin
                        errors++;
                        $display("FAIL buf_waddr: got %0d want %0d", rw.buf_waddr, mon_addr);
                    end
                end
                row_accepts = 0;
                commits++;
            end
        end
    end

    // One clock: drive all inputs just after the active edge
    task automatic cycle();
        bit v;
        @(posedge clk);
        #1;
        rst   = rst_drive;
        start = 1'b0;
        if (start_q.size() > 0) begin
            if (start_q[0] == cyc) begin
                start = 1'b1;
                void'(start_q.pop_front());
            end
        end
        rw.buf_ready = ready_drive;
        case (valid_mode)
            0:       v = 1'b0;
            1:       v = 1'b1;
            default: v = ($urandom_range(0, 1) == 1);
        endcase
        rw.pix_valid = v;
        // pixel index = row*ROW_PIX + col, truncated to 12 bits
        rw.pix_data  = pixel_t'(acc_total);
        if (v && pushed_idx != acc_total) begin
            exp_pix_q.push_back(pixel_t'(acc_total));
            pushed_idx = acc_total;
        end
    endtask

    task automatic clear_sb();
        exp_pix_q.delete();
        exp_addr_q.delete();
        start_q.delete();
        acc_total   = 0;
        pushed_idx  = -1;
        row_accepts = 0;
        commits     = 0;
        fd_count    = 0;
        fd_cyc      = -1;
        busy_cycles = 0;
    endtask

    task automatic do_reset();
        rst_drive = 1'b1;
        cycle();
        cycle();
        rst_drive = 1'b0;
        cycle();
        clear_sb();
    endtask

    task automatic load_addrs();
        for (int r = 0; r < NUM_ROWS; r++) exp_addr_q.push_back(exp_addr(r));
    endtask

    task automatic test_reset();
        rst_drive   = 1'b1;
        valid_mode  = 1;
        ready_drive = 1'b1;
        repeat (3) cycle();
        @(negedge clk);
        checks += 6;
        if (rw.pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b want 0", rw.pix_ready); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (rw.buf_we !== 1'b0)    begin errors++; $display("FAIL reset_buf_we: got %b want 0", rw.buf_we); end
        if (rw.buf_waddr !== '0)   begin errors++; $display("FAIL reset_buf_waddr: got %0d want 0", rw.buf_waddr); end
        if (frame_done !== 1'b0)   begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        if (rw.accum_we !== 1'b0)  begin errors++; $display("FAIL reset_accum_we: got %b want 0", rw.accum_we); end
        rst_drive = 1'b0;
        cycle();
        cycle();
        @(negedge clk);
        checks += 2;
        if (rw.pix_ready !== 1'b0) begin errors++; $display("FAIL idle_pix_ready: got %b want 0", rw.pix_ready); end
        if (rw.accum_we !== 1'b0)  begin errors++; $display("FAIL idle_accum_we: got %b want 0", rw.accum_we); end
    endtask

    task automatic test_full_frame();
        int s;
        int n;
        do_reset();
        load_addrs();
        valid_mode  = 1;
        ready_drive = 1'b1;
        start_q.push_back(cyc + 1);
        cycle();
        s = cyc + 1;                                   // edge that samples start
        start_q.push_back(s + 1000);                   // mid-frame, in FILL
        start_q.push_back(s + NUM_ROWS * (ROW_PIX + 1)); // lands on the DONE cycle
        n = 0;
        while (fd_count == 0 && n < NUM_ROWS * (ROW_PIX + 1) + 50) begin
            cycle();
            n++;
        end
        repeat (8) cycle();
        @(negedge clk);
        checks++;
        if (fd_count != 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", fd_count); end
        checks++;
        if (fd_cyc - s != NUM_ROWS * (ROW_PIX + 1)) begin
            errors++; $display("FAIL frame_done_time: got %0d want %0d", fd_cyc - s, NUM_ROWS * (ROW_PIX + 1));
        end
        checks++;
        if (busy_cycles != NUM_ROWS * (ROW_PIX + 1) + 1) begin
            errors++; $display("FAIL frame_busy_cycles: got %0d want %0d", busy_cycles, NUM_ROWS * (ROW_PIX + 1) + 1);
        end
        checks++;
        if (commits != NUM_ROWS) begin errors++; $display("FAIL frame_commits: got %0d want %0d", commits, NUM_ROWS); end
        checks++;
        if (exp_addr_q.size() != 0) begin errors++; $display("FAIL frame_addr_left: got %0d want 0", exp_addr_q.size()); end
        checks++;
        if (acc_total != NUM_ROWS * ROW_PIX) begin
            errors++; $display("FAIL frame_accepts: got %0d want %0d", acc_total, NUM_ROWS * ROW_PIX);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL frame_restart_ignored: busy got %b want 0", busy); end
    endtask

    task automatic test_commit_stall();
        int n;
        do_reset();
        load_addrs();
        valid_mode  = 1;
        ready_drive = 1'b1;
        start_q.push_back(cyc + 1);
        n = 0;
        while (commits < 3 && n < 1000) begin cycle(); n++; end
        ready_drive = 1'b0;
        n = 0;
        do begin
            cycle();
            @(negedge clk);
            n++;
        end while (rw.buf_we !== 1'b1 && n < 400);
        checks++;
        if (rw.buf_we !== 1'b1 || commits != 3) begin
            errors++; $display("FAIL stall_reach_row3: buf_we %b commits %0d want 1 and 3", rw.buf_we, commits);
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                ready_drive = (i == 5);
                cycle();
                @(negedge clk);
            end
            checks += 4;
            if (rw.buf_we !== 1'b1)          begin errors++; $display("FAIL stall_buf_we[%0d]: got %b want 1", i, rw.buf_we); end
            if (rw.buf_waddr !== exp_addr(3)) begin errors++; $display("FAIL stall_waddr[%0d]: got %0d want %0d", i, rw.buf_waddr, exp_addr(3)); end
            if (rw.pix_ready !== 1'b0)       begin errors++; $display("FAIL stall_pix_ready[%0d]: got %b want 0", i, rw.pix_ready); end
            if (rw.accum_we !== 1'b0)        begin errors++; $display("FAIL stall_accum_we[%0d]: got %b want 0", i, rw.accum_we); end
        end
        ready_drive = 1'b1;
        cycle();
        @(negedge clk);
        checks += 3;
        if (rw.buf_we !== 1'b0)    begin errors++; $display("FAIL stall_release_buf_we: got %b want 0", rw.buf_we); end
        if (rw.pix_ready !== 1'b1) begin errors++; $display("FAIL stall_release_pix_ready: got %b want 1", rw.pix_ready); end
        if (commits != 4)          begin errors++; $display("FAIL stall_commits: got %0d want 4", commits); end
    endtask

    task automatic test_valid_toggle();
        int n;
        do_reset();
        load_addrs();
        valid_mode  = 2;
        ready_drive = 1'b1;
        start_q.push_back(cyc + 1);
        n = 0;
        while (commits < 2 && n < 4000) begin cycle(); n++; end
        checks++;
        if (commits != 2) begin errors++; $display("FAIL toggle_commits: got %0d want 2", commits); end
        checks++;
        if (acc_total != 2 * ROW_PIX) begin errors++; $display("FAIL toggle_accepts: got %0d want %0d", acc_total, 2 * ROW_PIX); end
        valid_mode = 1;
    endtask

    task automatic test_reset_abort();
        int n;
        int bad_we;
        do_reset();
        load_addrs();
        valid_mode  = 1;
        ready_drive = 1'b1;
        start_q.push_back(cyc + 1);
        n = 0;
        while (acc_total < 7 * ROW_PIX + 100 && n < 3000) begin cycle(); n++; end
        checks++;
        if (commits != 7) begin errors++; $display("FAIL abort_rows_before: got %0d want 7", commits); end
        rst_drive = 1'b1;
        cycle();
        rst_drive = 1'b0;
        cycle();
        @(negedge clk);
        checks += 3;
        if (busy !== 1'b0)         begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (rw.pix_ready !== 1'b0) begin errors++; $display("FAIL abort_pix_ready: got %b want 0", rw.pix_ready); end
        if (rw.buf_we !== 1'b0)    begin errors++; $display("FAIL abort_buf_we: got %b want 0", rw.buf_we); end
        cycle();
        clear_sb();
        bad_we = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            @(negedge clk);
            if (rw.buf_we !== 1'b0 || busy !== 1'b0) bad_we++;
        end
        checks++;
        if (bad_we != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad_we); end
        exp_addr_q.push_back(exp_addr(0));
        start_q.push_back(cyc + 1);
        n = 0;
        while (commits < 1 && n < 600) begin cycle(); n++; end
        checks++;
        if (commits != 1) begin errors++; $display("FAIL abort_restart_commit: got %0d want 1", commits); end
        checks++;
        if (acc_total != ROW_PIX) begin errors++; $display("FAIL abort_restart_accepts: got %0d want %0d", acc_total, ROW_PIX); end
    endtask

    initial begin
        rw.pix_valid = 1'b0;
        rw.pix_data  = '0;
        rw.buf_ready = 1'b1;
        test_reset();
        test_full_frame();
        test_commit_stall();
        test_valid_toggle();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_row_writer
`default_nettype wire
